// File: rtl/mult_lp_pkg.sv
// Shared helpers for the mult_lp_v2 streaming multiplier: stage count and per-stage bit count.
package mult_lp_pkg;

   function automatic int unsigned stages_f(int unsigned w, int unsigned bps);
      return (w + bps - 1) / bps;
   endfunction

   // The final stage retires whatever bits remain when W is not a multiple of BPS.
   function automatic int unsigned stage_bits_f(int unsigned w, int unsigned bps,
                                                int unsigned s);
      return (s == stages_f(w, bps) - 1) ? (w - bps * s) : bps;
   endfunction

endpackage

// File: rtl/mult_lp_stage.sv
// One shift-and-add stage: retires Nb multiplier bits; the last stage also applies the sign.
// Optional tag storage is enabled by MULT_LP_V2_TAG_EN.
module mult_lp_stage #(
   parameter int unsigned W    = 8,
   parameter int unsigned Nb   = 1,
   parameter bit          Last = 1'b0
`ifdef MULT_LP_V2_TAG_EN
   , parameter int unsigned TagW = 4
`endif
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           adv_i,
   input  logic           valid_i,
   input  logic           neg_i,
   input  logic [2*W-1:0] acc_i,
   input  logic [W-1:0]   mpl_i,
   input  logic [2*W-1:0] mcd_i,
`ifdef MULT_LP_V2_TAG_EN
   input  logic [TagW-1:0] tag_i,
   output logic [TagW-1:0] tag_o,
`endif
   output logic           valid_o,
   output logic           neg_o,
   output logic [2*W-1:0] acc_o,
   output logic [W-1:0]   mpl_o,
   output logic [2*W-1:0] mcd_o
);

   logic           valid_q, valid_d;
   logic           neg_q, neg_d;
   logic [2*W-1:0] acc_q, acc_d;
   logic [W-1:0]   mpl_q, mpl_d;
   logic [2*W-1:0] mcd_q, mcd_d;
   logic [2*W-1:0] sum;

   always_comb begin
      sum = acc_i;
      for (int unsigned i = 0; i < Nb; i++) begin
         if (mpl_i[i]) sum = sum + (mcd_i << i);
      end
      valid_d = valid_q;
      neg_d   = neg_q;
      acc_d   = acc_q;
      mpl_d   = mpl_q;
      mcd_d   = mcd_q;
      if (adv_i) begin
         valid_d = valid_i;
         neg_d   = neg_i;
         acc_d   = (Last && neg_i) ? -sum : sum;
         mpl_d   = mpl_i >> Nb;
         mcd_d   = mcd_i << Nb;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         neg_q   <= 1'b0;
         acc_q   <= '0;
         mpl_q   <= '0;
         mcd_q   <= '0;
      end else begin
         valid_q <= valid_d;
         neg_q   <= neg_d;
         acc_q   <= acc_d;
         mpl_q   <= mpl_d;
         mcd_q   <= mcd_d;
      end
   end

`ifdef MULT_LP_V2_TAG_EN
   logic [TagW-1:0] tag_q, tag_d;

   always_comb begin
      tag_d = tag_q;
      if (adv_i) tag_d = tag_i;
   end

   always_ff @(posedge clk) begin
      if (rst) tag_q <= '0;
      else     tag_q <= tag_d;
   end

   assign tag_o = tag_q;
`endif

   assign valid_o = valid_q;
   assign neg_o   = neg_q;
   assign acc_o   = acc_q;
   assign mpl_o   = mpl_q;
   assign mcd_o   = mcd_q;

endmodule

// File: rtl/mult_lp_v2.sv
// Pipelined signed/unsigned shift-and-add multiplier with valid/ready backpressure.
// Define MULT_LP_V2_TAG_EN to carry a per-operation tag alongside each result.
module mult_lp_v2
   import mult_lp_pkg::*;
#(
   parameter int unsigned W   = 8,
   parameter int unsigned BPS = 1
`ifdef MULT_LP_V2_TAG_EN
   , parameter int unsigned TAG_W = 4
`endif
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic           sgn,
   input  logic [W-1:0]   dA,
   input  logic [W-1:0]   dB,
`ifdef MULT_LP_V2_TAG_EN
   input  logic [TAG_W-1:0] in_tag,
   output logic [TAG_W-1:0] out_tag,
`endif
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] a_mult_b
);

   localparam int unsigned STAGES = stages_f(W, BPS);

   logic adv;
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // Index 0 is the input register; index s+1 is the output of stage s.
   logic           st_valid [0:STAGES];
   logic           st_neg   [0:STAGES];
   logic [2*W-1:0] st_acc   [0:STAGES];
   logic [W-1:0]   st_mpl   [0:STAGES];
   logic [2*W-1:0] st_mcd   [0:STAGES];

   logic           in_valid_q, in_valid_d;
   logic           in_neg_q, in_neg_d;
   logic [W-1:0]   in_mpl_q, in_mpl_d;
   logic [2*W-1:0] in_mcd_q, in_mcd_d;

   // Magnitudes are taken here so the stages only ever add; -2^(W-1) still fits in W bits.
   always_comb begin
      in_valid_d = in_valid_q;
      in_neg_d   = in_neg_q;
      in_mpl_d   = in_mpl_q;
      in_mcd_d   = in_mcd_q;
      if (adv) begin
         in_valid_d = in_valid;
         in_neg_d   = sgn && (dA[W-1] ^ dB[W-1]);
         in_mpl_d   = (sgn && dB[W-1]) ? -dB : dB;
         in_mcd_d   = {{W{1'b0}}, ((sgn && dA[W-1]) ? -dA : dA)};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_valid_q <= 1'b0;
         in_neg_q   <= 1'b0;
         in_mpl_q   <= '0;
         in_mcd_q   <= '0;
      end else begin
         in_valid_q <= in_valid_d;
         in_neg_q   <= in_neg_d;
         in_mpl_q   <= in_mpl_d;
         in_mcd_q   <= in_mcd_d;
      end
   end

   assign st_valid[0] = in_valid_q;
   assign st_neg[0]   = in_neg_q;
   assign st_acc[0]   = '0;
   assign st_mpl[0]   = in_mpl_q;
   assign st_mcd[0]   = in_mcd_q;

`ifdef MULT_LP_V2_TAG_EN
   logic [TAG_W-1:0] in_tag_q, in_tag_d;
   logic [TAG_W-1:0] st_tag [0:STAGES];

   always_comb begin
      in_tag_d = in_tag_q;
      if (adv) in_tag_d = in_tag;
   end

   always_ff @(posedge clk) begin
      if (rst) in_tag_q <= '0;
      else     in_tag_q <= in_tag_d;
   end

   assign st_tag[0] = in_tag_q;
   assign out_tag   = st_tag[STAGES];
`endif

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      mult_lp_stage #(
         .W    (W),
         .Nb   (stage_bits_f(W, BPS, s)),
         .Last (s == STAGES - 1)
`ifdef MULT_LP_V2_TAG_EN
         , .TagW (TAG_W)
`endif
      ) u_stage (
         .clk     (clk),
         .rst     (rst),
         .adv_i   (adv),
         .valid_i (st_valid[s]),
         .neg_i   (st_neg[s]),
         .acc_i   (st_acc[s]),
         .mpl_i   (st_mpl[s]),
         .mcd_i   (st_mcd[s]),
`ifdef MULT_LP_V2_TAG_EN
         .tag_i   (st_tag[s]),
         .tag_o   (st_tag[s+1]),
`endif
         .valid_o (st_valid[s+1]),
         .neg_o   (st_neg[s+1]),
         .acc_o   (st_acc[s+1]),
         .mpl_o   (st_mpl[s+1]),
         .mcd_o   (st_mcd[s+1])
      );
   end

   assign out_valid = st_valid[STAGES];
   assign a_mult_b  = st_acc[STAGES];

   logic unused_tail;
   assign unused_tail = ^{st_neg[STAGES], st_mpl[STAGES], st_mcd[STAGES]};

endmodule

// File: tb/tb_mult_lp_v2.sv
// Randomised bench for mult_lp_v2 (W=8, BPS=3: uneven last stage) against an arithmetic model.
module tb_mult_lp_v2;
   localparam int unsigned W      = 8;
   localparam int unsigned BPS    = 3;
   localparam int unsigned STAGES = (W + BPS - 1) / BPS;
   localparam int          LAT    = STAGES + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst = 1'b1;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic           sgn = 1'b0;
   logic [W-1:0]   dA = '0;
   logic [W-1:0]   dB = '0;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [2*W-1:0] a_mult_b;
`ifdef MULT_LP_V2_TAG_EN
   logic [3:0] in_tag = '0;
   logic [3:0] out_tag;
`endif

   mult_lp_v2 #(.W(W), .BPS(BPS)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sgn       (sgn),
      .dA        (dA),
      .dB        (dB),
`ifdef MULT_LP_V2_TAG_EN
      .in_tag    (in_tag),
      .out_tag   (out_tag),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .a_mult_b  (a_mult_b)
   );

   typedef struct {
      logic [2*W-1:0] prod;
      logic [3:0]     tag;
      int             cyc;
   } exp_t;

   exp_t           q[$];
   int             n_total = 0;
   int             n_bad   = 0;
   int             cyc     = 0;
   bit             lat_chk = 1'b0;
   bit             hold    = 1'b0;
   logic [2*W-1:0] hold_val;
   logic [3:0]     tag_ctr = '0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic s);
      longint av, bv, p;
      av = longint'(a);
      bv = longint'(b);
      if (s && a[W-1]) av = av - (longint'(1) << W);
      if (s && b[W-1]) bv = bv - (longint'(1) << W);
      p = av * bv;
      return p[2*W-1:0];
   endfunction

   task automatic step(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input logic ordy);
      exp_t e;
      @(negedge clk);
      in_valid  = iv;
      dA        = a;
      dB        = b;
      sgn       = s;
      out_ready = ordy;
`ifdef MULT_LP_V2_TAG_EN
      in_tag    = tag_ctr;
`endif
      #1;
      if (ordy) check_eq("ready_when_drained", in_ready, 1);
      if (hold) begin
         check_eq("hold_valid", out_valid, 1);
         check_eq("hold_data", a_mult_b, hold_val);
         if (!ordy) check_eq("stall_in_ready", in_ready, 0);
      end
      if (lat_chk && q.size() > 0 && (cyc - q[0].cyc) >= LAT) check_eq("due", out_valid, 1);
      if (out_valid && out_ready) begin
         check_eq("result_expected", q.size() != 0, 1);
         if (q.size() != 0) begin
            e = q.pop_front();
            check_eq("product", a_mult_b, e.prod);
            if (lat_chk) check_eq("latency", cyc - e.cyc, LAT);
`ifdef MULT_LP_V2_TAG_EN
            check_eq("tag", out_tag, e.tag);
`endif
         end
      end
      if (iv && in_ready) begin
         e.prod = ref_mul(a, b, s);
         e.tag  = tag_ctr;
         e.cyc  = cyc;
         q.push_back(e);
         tag_ctr++;
      end
      hold     = out_valid && !out_ready;
      hold_val = a_mult_b;
      cyc++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_a_mult_b", a_mult_b, 0);
      check_eq("rst_in_ready", in_ready, 1);
      q.delete();
      hold = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 4 * LAT && q.size() > 0; i++) step(1'b0, '0, '0, 1'b0, 1'b1);
      check_eq("drained", q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] da_tab [6] = '{8'hFF, 8'h80, 8'h80, 8'h7F, 8'h00, 8'hFF};
      logic [W-1:0] db_tab [6] = '{8'hFF, 8'h80, 8'h7F, 8'hFF, 8'hFF, 8'hFF};
      logic         sg_tab [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

      do_reset();

      // Back-to-back stream at full rate: latency and gap-free output are checked.
      lat_chk = 1'b1;
      for (int i = 0; i < 6; i++) step(1'b1, da_tab[i], db_tab[i], sg_tab[i], 1'b1);
      for (int i = 0; i < 60; i++)
         step(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b1);
      drain();
      lat_chk = 1'b0;

      // Random backpressure with a forced 10-cycle stall in the middle.
      for (int i = 0; i < 150; i++)
         step(($urandom_range(0, 3) != 0), W'($urandom), W'($urandom), 1'($urandom),
              (i >= 60 && i < 70) ? 1'b0 : 1'($urandom));
      drain();

      // Reset with three operations in flight; none of them may emerge.
      for (int i = 0; i < 3; i++) step(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b1);
      do_reset();
      for (int i = 0; i < LAT + 2; i++) begin
         step(1'b0, '0, '0, 1'b0, 1'b1);
         check_eq("rst_quiet", out_valid, 0);
      end
      lat_chk = 1'b1;
      step(1'b1, 8'd3, 8'd5, 1'b0, 1'b1);
      drain();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
